alu_datapath_mc: RTL and testbench
==================================

# alu_datapath_mc

Parametrised, clocked successor to the miniMIPS ALU datapath. It provides registered A/B operand capture with source muxes, a combinational single-cycle ALU, and an optional iterative multi-cycle shifter. Results are reported through a start/busy/done handshake. It sits between the register file/PC/instruction register and the multicycle controller.

## Interface
Parameters:
- `WIDTH`, default 8: datapath width; power of two, ≥4.
- `PC_INC`, default 1: constant selected on srcB sel 01.
- `IMM_SHIFT`, default 2: left shift applied to `imm` on srcB sel 11.

Derived constant:
- `SHAMT_W` = $clog2(WIDTH).

Ports:
- `clk` — in, 1: single clock; all state updates on posedge.
- `rst` — in, 1: asynchronous, active-high reset.
- `pc` — in, WIDTH: program counter, srcA sel 0.
- `rd1` — in, WIDTH: register data, srcA sel 1.
- `rd2` — in, WIDTH: register data, srcB sel 00.
- `instr` — in, WIDTH: instruction field, srcB sel 10.
- `imm` — in, WIDTH: immediate, srcB sel 11 (`imm << IMM_SHIFT`, truncated to WIDTH).
- `srca_sel` — in, 1: A source select.
- `srcb_sel` — in, 2: B source select.
- `a_en` — in, 1: load A register from the srcA mux.
- `b_en` — in, 1: load B register from the srcB mux.
- `alu_cntrl` — in, 3: operation code, sampled with `start`.
- `start` — in, 1: request operation on the current A/B register contents.
- `busy` — out, 1: multi-cycle operation in progress.
- `done` — out, 1: one-cycle pulse; `alu_out`/`zero_out` newly valid.
- `alu_out` — out, WIDTH: registered result.
- `zero_out` — out, 1: registered (`alu_out` == 0).

## Operation
- A/B registers load independently on `a_en`/`b_en`, in any state. The ALU always reads register contents, never mux outputs; `a_en` and `start` in the same cycle uses the old A.
- Op codes:
  - 000 AND, 001 OR, 010 ADD, 110 SUB (A−B): result truncated to WIDTH, carry discarded.
  - 111 SLT: signed A<B, computed as sum MSB XOR overflow of A−B; result zero-extended to WIDTH (0 or 1).
  - 011 SLL, 100 SRL: shift A by B[SHAMT_W-1:0], logical.
  - 101: reserved; result 0.
- FSM states: IDLE and SHIFT.
  - IDLE, `start`, non-shift op (or shamt = 0): write result; `done` = 1 next cycle; stay in IDLE.
  - IDLE, `start`, shift op with shamt > 0: load working register ← A and count ← shamt; go to SHIFT.
  - SHIFT: each edge shifts the working register by 1 and decrements count. On the edge where count goes 1→0, write `alu_out`/`zero_out`, pulse `done`, and return to IDLE.
- `start` while in SHIFT is ignored; there is no queueing. A/B reloads during SHIFT do not affect the working register.
- Reset (asynchronous, any state): go to IDLE. `alu_out` = 0, `zero_out` = 0, `done` = 0, `busy` = 0. A/B, working register and count are all 0.

## Timing
- Single-cycle op latency: `start` sampled at edge N; result and `done` visible after edge N.
- Shift latency: shamt edges after the start edge. `busy` is high from edge N through the result edge, and falls in the same cycle `done` rises.
- `done` is high for exactly one cycle per accepted `start`.
- `alu_out` holds its value between operations.
- Back-to-back: a new `start` is accepted in the `done` cycle.

## Configuration
- `ALU_DP_SHIFT_EN` defined: SLL/SRL work as described, with the SHIFT state, working register and counter.
- `ALU_DP_SHIFT_EN` undefined: no SHIFT state and no shifter. Codes 011/100 execute single-cycle with result 0 and `zero_out` = 1. `busy` is tied to 0.

## Structure
- Package `alu_dp_pkg` holds:
  - op-code localparams (`OP_AND` … `OP_SLT`);
  - srcB select encodings (`SRCB_REG`, `SRCB_INC`, `SRCB_INSTR`, `SRCB_IMM`);
  - FSM state enum.
- Sub-module `alu_core`: combinational WIDTH-parametrised AND/OR/ADD/SUB/SLT plus zero detect. Shifting stays in the top level.

## Test plan
- ADD: A=0x7F (rd1, srca_sel=1), B=0x01 (rd2, srcb_sel=00), `start` op 010 → next cycle `done`=1, `alu_out`=0x80, `zero_out`=0.
- SUB equal: A=0x33, B=0x33, op 110 → `alu_out`=0x00, `zero_out`=1; a following AND 0xF0&0x3C → 0x30.
- SLT overflow: A=0x80, B=0x01 → 0x01. A=0x7F, B=0xFF → 0x00.
- Sources: pc=0x10, srca_sel=0, srcb_sel=01, ADD → 0x11. srcb_sel=11 with imm=0x03 → 0x1C.
- SLL (macro on): A=0x81, B=0x03 → `busy` high 3 cycles, `done` on cycle 3, `alu_out`=0x08. A `start` pulse mid-shift produces no extra `done`. SRL of 0x80 by 0 → single-cycle, 0x80.
- Reset mid-shift: `rst` asserted on cycle 2 of an SLL by 5 → `busy`, `done`, `alu_out`, `zero_out` are 0 immediately. After release, ADD 0x02+0x03 → 0x05.

Source files
------------

// File: rtl/alu_datapath_mc_pkg.sv
// alu_dp_pkg: shared encodings for the alu_datapath_mc slice.
//   - ALU op codes (OP_AND .. OP_SLT)
//   - srcB mux select encodings (SRCB_REG .. SRCB_IMM)
//   - control FSM state enum
//   - is_shift_op(): true for the codes handled by the iterative shifter
package alu_dp_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SLL  = 3'b011;
  localparam logic [2:0] OP_SRL  = 3'b100;
  localparam logic [2:0] OP_RSVD = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_INC   = 2'b01;
  localparam logic [1:0] SRCB_INSTR = 2'b10;
  localparam logic [1:0] SRCB_IMM   = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/alu_datapath_mc_alu_core.sv
// alu_core: combinational single-cycle ALU (AND/OR/ADD/SUB/SLT) with zero flag.
// Shift codes and the reserved code produce 0 here; shifting lives in the top.
// Ports:
//   a, b  : operands (WIDTH)
//   op    : operation code (3)
//   y     : result (WIDTH), carry discarded
//   zero  : y == 0
module alu_core
  import alu_dp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             zero
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf;
  logic             slt;

  assign sum  = a + b;
  assign diff = a - b;
  // Signed overflow of A-B: operands differ in sign and the result sign
  // differs from A. The true sign of A-B is then diff MSB XOR overflow.
  assign ovf  = (a[WIDTH-1] ^ b[WIDTH-1]) & (diff[WIDTH-1] ^ a[WIDTH-1]);
  assign slt  = diff[WIDTH-1] ^ ovf;

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_ADD:  y = sum;
      OP_SUB:  y = diff;
      OP_SLT:  y = {{(WIDTH-1){1'b0}}, slt};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/alu_datapath_mc.sv
// alu_datapath_mc: registered A/B operand capture with source muxes, a
// single-cycle ALU and an optional iterative shifter, reported through a
// start/busy/done handshake.
// Build option: define ALU_DP_SHIFT_EN to enable SLL/SRL via the SHIFT state;
// without it, shift codes complete in one cycle with result 0 and busy is 0.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   pc, rd1             : srcA sources (sel 0 / 1)
//   rd2, instr, imm     : srcB sources (sel 00 / 10 / 11 as imm<<IMM_SHIFT);
//                         sel 01 is the constant PC_INC
//   srca_sel, srcb_sel  : source selects
//   a_en, b_en          : load A / B registers from the muxes
//   alu_cntrl, start    : op code, sampled when start is high
//   busy, done          : multi-cycle in progress / one-cycle result pulse
//   alu_out, zero_out   : registered result and its zero flag
module alu_datapath_mc
  import alu_dp_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int PC_INC    = 1,
  parameter int IMM_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [WIDTH-1:0] instr,
  input  logic [WIDTH-1:0] imm,
  input  logic             srca_sel,
  input  logic [1:0]       srcb_sel,
  input  logic             a_en,
  input  logic             b_en,
  input  logic [2:0]       alu_cntrl,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero_out
);

  localparam int               SHAMT_W  = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] PC_INC_W = WIDTH'(PC_INC);

  logic [WIDTH-1:0] srca_mux;
  logic [WIDTH-1:0] srcb_mux;
  logic [WIDTH-1:0] imm_sh;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] core_y;
  logic             core_zero;

  assign imm_sh   = imm << IMM_SHIFT;
  assign srca_mux = srca_sel ? rd1 : pc;

  always_comb begin
    srcb_mux = rd2;
    case (srcb_sel)
      SRCB_REG:   srcb_mux = rd2;
      SRCB_INC:   srcb_mux = PC_INC_W;
      SRCB_INSTR: srcb_mux = instr;
      SRCB_IMM:   srcb_mux = imm_sh;
      default:    srcb_mux = rd2;
    endcase
  end

  // The ALU sees register contents only, so a same-cycle a_en/start pair
  // operates on the previous A.
  alu_core #(.WIDTH(WIDTH)) u_core (
    .a    (a_q),
    .b    (b_q),
    .op   (alu_cntrl),
    .y    (core_y),
    .zero (core_zero)
  );

`ifdef ALU_DP_SHIFT_EN
  state_e               state_q, state_d;
  logic [WIDTH-1:0]     work_q, work_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
  logic                 dir_q, dir_d;   // 1 = right (SRL)
  logic                 busy_q, busy_d;
  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     work_step;

  assign shamt     = b_q[SHAMT_W-1:0];
  assign work_step = dir_q ? (work_q >> 1) : (work_q << 1);
`endif

  always_comb begin
    a_d       = a_en ? srca_mux : a_q;
    b_d       = b_en ? srcb_mux : b_q;
    alu_out_d = alu_out_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
`ifdef ALU_DP_SHIFT_EN
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    busy_d    = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (is_shift_op(alu_cntrl) && (shamt != '0)) begin
            // Snapshot A so later A reloads cannot disturb the shift.
            work_d  = a_q;
            cnt_d   = shamt;
            dir_d   = (alu_cntrl == OP_SRL);
            busy_d  = 1'b1;
            state_d = ST_SHIFT;
          end else if (is_shift_op(alu_cntrl)) begin
            alu_out_d = a_q;
            zero_d    = (a_q == '0);
            done_d    = 1'b1;
          end else begin
            alu_out_d = core_y;
            zero_d    = core_zero;
            done_d    = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        // start is deliberately ignored here; nothing is queued.
        work_d = work_step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          alu_out_d = work_step;
          zero_d    = (work_step == '0);
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = ST_IDLE;
        end
      end
    endcase
`else
    // Shift codes fall through alu_core, which returns 0 for them.
    if (start) begin
      alu_out_d = core_y;
      zero_d    = core_zero;
      done_d    = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      alu_out_q <= '0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ALU_DP_SHIFT_EN
      state_q   <= ST_IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      dir_q     <= 1'b0;
      busy_q    <= 1'b0;
`endif
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      alu_out_q <= alu_out_d;
      zero_q    <= zero_d;
      done_q    <= done_d;
`ifdef ALU_DP_SHIFT_EN
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      busy_q    <= busy_d;
`endif
    end
  end

`ifdef ALU_DP_SHIFT_EN
  assign busy = busy_q;
`else
  assign busy = 1'b0;
`endif
  assign done     = done_q;
  assign alu_out  = alu_out_q;
  assign zero_out = zero_q;

endmodule

// File: tb/tb_alu_datapath_mc.sv
// Directed testbench for alu_datapath_mc (WIDTH=8). Follows the DUT build:
// shift checks differ depending on whether ALU_DP_SHIFT_EN is defined.
module tb_alu_datapath_mc;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] pc = '0, rd1 = '0, rd2 = '0, instr = '0, imm = '0;
  logic       srca_sel = 1'b0;
  logic [1:0] srcb_sel = 2'b00;
  logic       a_en = 1'b0, b_en = 1'b0;
  logic [2:0] alu_cntrl = 3'b000;
  logic       start = 1'b0;
  logic       busy, done, zero_out;
  logic [7:0] alu_out;

  int vectors     = 0;
  int miscompares = 0;

  alu_datapath_mc #(.WIDTH(8), .PC_INC(1), .IMM_SHIFT(2)) dut (
    .clk(clk), .rst(rst), .pc(pc), .rd1(rd1), .rd2(rd2), .instr(instr),
    .imm(imm), .srca_sel(srca_sel), .srcb_sel(srcb_sel), .a_en(a_en),
    .b_en(b_en), .alu_cntrl(alu_cntrl), .start(start), .busy(busy),
    .done(done), .alu_out(alu_out), .zero_out(zero_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_regs(input logic [7:0] a, input logic [7:0] b);
    srca_sel = 1'b1; rd1 = a; srcb_sel = 2'b00; rd2 = b;
    a_en = 1'b1; b_en = 1'b1;
    tick();
    a_en = 1'b0; b_en = 1'b0;
  endtask

  task automatic fire(input logic [2:0] op);
    alu_cntrl = op; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    vectors++; if (alu_out !== 8'h00) begin miscompares++; $display("FAIL reset_alu_out got %h want 00", alu_out); end
    vectors++; if (zero_out !== 1'b0) begin miscompares++; $display("FAIL reset_zero got %b want 0", zero_out); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    load_regs(8'h7F, 8'h01);
    fire(3'b010);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL add_done got %b want 1", done); end
    vectors++; if (alu_out !== 8'h80) begin miscompares++; $display("FAIL add_out got %h want 80", alu_out); end
    vectors++; if (zero_out !== 1'b0) begin miscompares++; $display("FAIL add_zero got %b want 0", zero_out); end
    tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL add_done_pulse got %b want 0", done); end
    vectors++; if (alu_out !== 8'h80) begin miscompares++; $display("FAIL add_hold got %h want 80", alu_out); end
  endtask

  task automatic test_logic_sub();
    load_regs(8'h33, 8'h33);
    fire(3'b110);
    vectors++; if (alu_out !== 8'h00) begin miscompares++; $display("FAIL sub_eq_out got %h want 00", alu_out); end
    vectors++; if (zero_out !== 1'b1) begin miscompares++; $display("FAIL sub_eq_zero got %b want 1", zero_out); end
    load_regs(8'hF0, 8'h3C);
    fire(3'b000);
    vectors++; if (alu_out !== 8'h30) begin miscompares++; $display("FAIL and_out got %h want 30", alu_out); end
    vectors++; if (zero_out !== 1'b0) begin miscompares++; $display("FAIL and_zero got %b want 0", zero_out); end
    fire(3'b001);
    vectors++; if (alu_out !== 8'hFC) begin miscompares++; $display("FAIL or_out got %h want FC", alu_out); end
    load_regs(8'h03, 8'h05);
    fire(3'b110);
    vectors++; if (alu_out !== 8'hFE) begin miscompares++; $display("FAIL sub_wrap got %h want FE", alu_out); end
    fire(3'b101);
    vectors++; if (alu_out !== 8'h00 || zero_out !== 1'b1) begin miscompares++; $display("FAIL rsvd got %h/%b want 00/1", alu_out, zero_out); end
  endtask

  task automatic test_slt();
    load_regs(8'h80, 8'h01);
    fire(3'b111);
    vectors++; if (alu_out !== 8'h01) begin miscompares++; $display("FAIL slt_neg got %h want 01", alu_out); end
    load_regs(8'h7F, 8'hFF);
    fire(3'b111);
    vectors++; if (alu_out !== 8'h00 || zero_out !== 1'b1) begin miscompares++; $display("FAIL slt_ovf got %h/%b want 00/1", alu_out, zero_out); end
    load_regs(8'hFE, 8'hFF);
    fire(3'b111);
    vectors++; if (alu_out !== 8'h01) begin miscompares++; $display("FAIL slt_negneg got %h want 01", alu_out); end
  endtask

  task automatic test_sources();
    pc = 8'h10; srca_sel = 1'b0; srcb_sel = 2'b01;
    a_en = 1'b1; b_en = 1'b1;
    tick();
    a_en = 1'b0; b_en = 1'b0;
    fire(3'b010);
    vectors++; if (alu_out !== 8'h11) begin miscompares++; $display("FAIL src_pcinc got %h want 11", alu_out); end
    imm = 8'h03; srcb_sel = 2'b11; b_en = 1'b1;
    tick();
    b_en = 1'b0;
    fire(3'b010);
    vectors++; if (alu_out !== 8'h1C) begin miscompares++; $display("FAIL src_imm got %h want 1C", alu_out); end
    instr = 8'h21; srcb_sel = 2'b10; b_en = 1'b1;
    tick();
    b_en = 1'b0;
    fire(3'b010);
    vectors++; if (alu_out !== 8'h31) begin miscompares++; $display("FAIL src_instr got %h want 31", alu_out); end
  endtask

  task automatic test_old_a();
    load_regs(8'h05, 8'h01);
    srca_sel = 1'b1; rd1 = 8'h20; a_en = 1'b1;
    fire(3'b010);
    a_en = 1'b0;
    vectors++; if (alu_out !== 8'h06) begin miscompares++; $display("FAIL old_a got %h want 06", alu_out); end
    fire(3'b010);
    vectors++; if (alu_out !== 8'h21) begin miscompares++; $display("FAIL new_a got %h want 21", alu_out); end
  endtask

  task automatic test_back_to_back();
    load_regs(8'h05, 8'h03);
    alu_cntrl = 3'b010; start = 1'b1;
    tick();
    vectors++; if (done !== 1'b1 || alu_out !== 8'h08) begin miscompares++; $display("FAIL b2b_first got %b/%h want 1/08", done, alu_out); end
    alu_cntrl = 3'b110;
    tick();
    start = 1'b0;
    vectors++; if (done !== 1'b1 || alu_out !== 8'h02) begin miscompares++; $display("FAIL b2b_second got %b/%h want 1/02", done, alu_out); end
    tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL b2b_end got %b want 0", done); end
  endtask

  task automatic test_shift();
`ifdef ALU_DP_SHIFT_EN
    int  n;
    bit  seen;
    load_regs(8'h81, 8'h03);
    fire(3'b011);
    vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL sll_c1 busy/done got %b/%b want 1/0", busy, done); end
    tick();
    vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL sll_c2 busy/done got %b/%b want 1/0", busy, done); end
    alu_cntrl = 3'b010; start = 1'b1;   // ignored while shifting
    tick();
    start = 1'b0;
    vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL sll_c3 busy/done got %b/%b want 1/0", busy, done); end
    tick();
    vectors++; if (busy !== 1'b0 || done !== 1'b1) begin miscompares++; $display("FAIL sll_end busy/done got %b/%b want 0/1", busy, done); end
    vectors++; if (alu_out !== 8'h08 || zero_out !== 1'b0) begin miscompares++; $display("FAIL sll_out got %h/%b want 08/0", alu_out, zero_out); end
    tick();
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL sll_no_extra got %b/%b want 0/0", done, busy); end
    load_regs(8'h80, 8'h00);
    fire(3'b100);
    vectors++; if (done !== 1'b1 || busy !== 1'b0 || alu_out !== 8'h80) begin miscompares++; $display("FAIL srl0 got %b/%b/%h want 1/0/80", done, busy, alu_out); end
    load_regs(8'h80, 8'h07);
    fire(3'b100);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    vectors++; if (!seen || n != 7) begin miscompares++; $display("FAIL srl7_latency got seen=%b n=%0d want 1/7", seen, n); end
    vectors++; if (alu_out !== 8'h01) begin miscompares++; $display("FAIL srl7_out got %h want 01", alu_out); end
`else
    load_regs(8'h81, 8'h03);
    fire(3'b011);
    vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL sll_off done/busy got %b/%b want 1/0", done, busy); end
    vectors++; if (alu_out !== 8'h00 || zero_out !== 1'b1) begin miscompares++; $display("FAIL sll_off_out got %h/%b want 00/1", alu_out, zero_out); end
    load_regs(8'h0F, 8'h01);
    fire(3'b010);
    fire(3'b100);
    vectors++; if (done !== 1'b1 || alu_out !== 8'h00 || zero_out !== 1'b1) begin miscompares++; $display("FAIL srl_off got %b/%h/%b want 1/00/1", done, alu_out, zero_out); end
`endif
  endtask

  task automatic test_reset_mid_op();
`ifdef ALU_DP_SHIFT_EN
    load_regs(8'h81, 8'h05);
    fire(3'b011);
    tick();
`else
    load_regs(8'h0F, 8'h01);
    fire(3'b010);
`endif
    #2 rst = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL rst_mid busy/done got %b/%b want 0/0", busy, done); end
    vectors++; if (alu_out !== 8'h00 || zero_out !== 1'b0) begin miscompares++; $display("FAIL rst_mid out got %h/%b want 00/0", alu_out, zero_out); end
    tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick(); tick();
    vectors++; if (done !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rst_quiet got %b/%b want 0/0", done, busy); end
    fire(3'b010);
    vectors++; if (alu_out !== 8'h00 || zero_out !== 1'b1) begin miscompares++; $display("FAIL rst_ab_cleared got %h/%b want 00/1", alu_out, zero_out); end
    load_regs(8'h02, 8'h03);
    fire(3'b010);
    vectors++; if (done !== 1'b1 || alu_out !== 8'h05 || zero_out !== 1'b0) begin miscompares++; $display("FAIL rst_after_add got %b/%h/%b want 1/05/0", done, alu_out, zero_out); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_logic_sub();
    test_slt();
    test_sources();
    test_old_a();
    test_back_to_back();
    test_shift();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
